// File: rtl/jtframe_ioctl2prog.sv
// jtframe_ioctl2prog: turns the byte-wide ioctl download stream into masked 16-bit SDRAM writes.
// Bytes are bank-mapped when pushed and queued, so the SDRAM may stall without losing SPI bytes.
//  state | meaning
//  IDLE  | waiting for a queued entry; pops it into the prog_* registers
//  WRITE | prog_we held with stable address/data/mask until prog_rdy
//  GAP   | one cycle with prog_we low before the next pop
module jtframe_ioctl2prog #(
    parameter int          SDRAMW    = 23,
    parameter logic [24:0] BA1_START = 25'h10_0000,
    parameter logic [24:0] BA2_START = 25'h18_0000,
    parameter logic [24:0] BA3_START = 25'h1C_0000,
    parameter logic        SWAB      = 1'b0,
    parameter int          FIFOW     = 2,
    parameter int          POST_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    output logic              prog_rd,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam int DEPTH = 1 << FIFOW;
    localparam int PW = (POST_WAIT > 0) ? $clog2(POST_WAIT + 1) : 1;
    localparam logic [PW-1:0] POST_LOAD = PW'(POST_WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

    typedef struct packed {
        logic [1:0]        ba;
        logic [SDRAMW-1:0] addr;
        logic [7:0]        data;
        logic [1:0]        mask;
    } entry_t;

    state_t           state_q, state_d;
    entry_t           mem_q [DEPTH];
    entry_t           push_entry, out_q, out_d;
    logic [FIFOW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFOW:0]   count_q, count_d;
    logic [PW-1:0]    post_q, post_d;
    logic             dl_q, overflow_q, overflow_d;
    logic [24:0]      off;
    logic             empty, full, push_req, push, pop, drop, dl_rise;
    logic             unused_off;

    always_comb begin
        push_entry = '0;
        off        = ioctl_addr;
        if (ioctl_addr >= BA3_START) begin
            push_entry.ba = 2'd3;
            off           = ioctl_addr - BA3_START;
        end else if (ioctl_addr >= BA2_START) begin
            push_entry.ba = 2'd2;
            off           = ioctl_addr - BA2_START;
        end else if (ioctl_addr >= BA1_START) begin
            push_entry.ba = 2'd1;
            off           = ioctl_addr - BA1_START;
        end
        push_entry.addr = off[SDRAMW:1];
        push_entry.data = ioctl_data;
        push_entry.mask = (off[0] ^ SWAB) ? 2'b01 : 2'b10;
    end

    // Offset bits above the SDRAM word address are deliberately truncated.
    assign unused_off = &{1'b0, off[24:SDRAMW+1]};

    assign empty    = (count_q == '0);
    assign full     = count_q[FIFOW];
    assign push_req = ioctl_wr & downloading;
    assign pop      = (state_q == S_IDLE) && !empty;
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;
    assign dl_rise  = downloading & ~dl_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        out_d = pop ? mem_q[rd_ptr_q] : out_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_WRITE;
            S_WRITE: if (prog_rdy) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // post_cnt restarts at the end of every drain that happens outside the download window.
    always_comb begin
        post_d = post_q;
        if (dl_rise) begin
            post_d = '0;
        end else if (state_q == S_GAP && !downloading && empty) begin
            post_d = POST_LOAD;
        end else if (post_q != '0) begin
            post_d = post_q - 1'b1;
        end
        overflow_d = dl_rise ? 1'b0 : overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            out_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            post_q     <= '0;
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            post_q     <= post_d;
            dl_q       <= downloading;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign prog_addr  = out_q.addr;
    assign prog_data  = {out_q.data, out_q.data};
    assign prog_mask  = out_q.mask;
    assign prog_ba    = out_q.ba;
    assign prog_we    = (state_q == S_WRITE);
    assign prog_rd    = 1'b0;
    assign overflow   = overflow_q;
    assign dwnld_busy = downloading | !empty | (state_q != S_IDLE) | (post_q != '0);

endmodule

// File: tb/tb_jtframe_ioctl2prog.sv
// Bench for jtframe_ioctl2prog: vector table plus scoreboard of expected SDRAM writes.
// A second instance with swapped byte lanes runs on the same stimulus.
module tb_jtframe_ioctl2prog;

    localparam int POST_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst, downloading, ioctl_wr, prog_rdy;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [22:0] prog_addr, s_addr;
    logic [15:0] prog_data, s_data;
    logic [1:0]  prog_mask, prog_ba, s_mask, s_ba;
    logic        prog_we, prog_rd, dwnld_busy, overflow;
    logic        s_we, s_rd, s_busy, s_ovf;

    jtframe_ioctl2prog dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
        .prog_we(prog_we), .prog_rd(prog_rd), .prog_rdy(prog_rdy),
        .dwnld_busy(dwnld_busy), .overflow(overflow)
    );

    jtframe_ioctl2prog #(.SWAB(1'b1)) dut_s (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(s_addr), .prog_data(s_data), .prog_mask(s_mask), .prog_ba(s_ba),
        .prog_we(s_we), .prog_rd(s_rd), .prog_rdy(prog_rdy),
        .dwnld_busy(s_busy), .overflow(s_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  d;
        int          gap;
        logic [1:0]  ba;
        logic [22:0] waddr;
        logic [1:0]  mask;
    } vec_t;

    typedef struct {
        logic [1:0]  ba;
        logic [22:0] waddr;
        logic [15:0] data;
        logic [1:0]  mask;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_rise = -1;
    logic we_prev = 1'b0;
    logic rdy_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [1:0] ba, input logic [22:0] wa, input logic [7:0] d,
                            input logic [1:0] m);
        exp_t e;
        e.ba = ba; e.waddr = wa; e.data = {d, d}; e.mask = m;
        sb.push_back(e);
    endtask

    task automatic drive_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || prog_we) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < limit), 32'd1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (dwnld_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_clears_in_time", 32'(n < limit), 32'd1);
    endtask

    // Monitor: each rising prog_we is one SDRAM write, checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                we_prev   = 1'b0;
                last_rise = -1;
            end else begin
                if (prog_we && !we_prev) begin
                    if (last_rise >= 0) check("write_period_ge3", 32'((cyc - last_rise) >= 3), 32'd1);
                    last_rise = cyc;
                    if (sb.size() == 0) begin
                        check("stray_write", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("prog_ba", 32'(prog_ba), 32'(e.ba));
                        check("prog_addr", 32'(prog_addr), 32'(e.waddr));
                        check("prog_data", 32'(prog_data), 32'(e.data));
                        check("prog_mask", 32'(prog_mask), 32'(e.mask));
                        check("swab_we", 32'(s_we), 32'd1);
                        check("swab_mask", 32'(s_mask), 32'({e.mask[0], e.mask[1]}));
                        check("prog_rd", 32'(prog_rd), 32'd0);
                    end
                end
                we_prev = prog_we;
            end
        end
    end

    // SDRAM model: answers each write with prog_rdy in its first cycle unless held off.
    initial begin
        forever begin
            @(negedge clk);
            if (!rdy_hold) prog_rdy = prog_we && !prog_rdy;
        end
    end

    initial begin
        int n, lows, high, falls;
        logic prev;

        vecs[0] = '{25'h000_0000, 8'h11, 0, 2'd0, 23'h000000, 2'b10};
        vecs[1] = '{25'h000_0001, 8'h22, 3, 2'd0, 23'h000000, 2'b01};
        vecs[2] = '{25'h018_0005, 8'h5A, 3, 2'd2, 23'h000002, 2'b01};
        vecs[3] = '{25'h010_0010, 8'h3C, 3, 2'd1, 23'h000008, 2'b10};
        vecs[4] = '{25'h01C_0007, 8'h77, 3, 2'd3, 23'h000003, 2'b01};
        vecs[5] = '{25'h00F_FFFF, 8'h81, 3, 2'd0, 23'h07FFFF, 2'b01};
        vecs[6] = '{25'h017_FFFE, 8'h96, 3, 2'd1, 23'h03FFFF, 2'b10};
        vecs[7] = '{25'h01C_0000, 8'hC3, 3, 2'd3, 23'h000000, 2'b10};
        vecs[8] = '{25'h1FF_FFFF, 8'hE7, 3, 2'd3, 23'h71FFFF, 2'b01};
        vecs[9] = '{25'h000_0ABC, 8'h42, 3, 2'd0, 23'h00055E, 2'b10};

        rst = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; prog_rdy = 1'b0;
        ioctl_addr = '0; ioctl_data = '0;
        repeat (3) @(negedge clk);
        check("rst_prog_we", 32'(prog_we), 32'd0);
        check("rst_prog_addr", 32'(prog_addr), 32'd0);
        check("rst_prog_data", 32'(prog_data), 32'd0);
        check("rst_prog_mask", 32'(prog_mask), 32'd0);
        check("rst_prog_ba", 32'(prog_ba), 32'd0);
        check("rst_prog_rd", 32'(prog_rd), 32'd0);
        check("rst_busy", 32'(dwnld_busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;

        // ioctl_wr outside the download window is ignored
        @(negedge clk);
        drive_byte(25'h0, 8'h55);
        repeat (5) @(negedge clk);
        check("ignored_wr_busy", 32'(dwnld_busy), 32'd0);

        // Bank map and lane select table
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            push_exp(vecs[i].ba, vecs[i].waddr, vecs[i].d, vecs[i].mask);
            drive_byte(vecs[i].addr, vecs[i].d);
            repeat (vecs[i].gap) @(negedge clk);
        end
        wait_drain(200);
        check("table_overflow", 32'(overflow), 32'd0);
        downloading = 1'b0;
        wait_idle(100);

        // Overflow: one byte sits in the prog_* registers, four fill the FIFO, the sixth drops
        downloading = 1'b1; rdy_hold = 1'b1; prog_rdy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i < 5) push_exp(2'd0, 23'(32'h20 + i), 8'(8'hA0 + i), 2'b10);
            if (i == 5) check("ovf_before_drop", 32'(overflow), 32'd0);
            drive_byte(25'(32'h40 + 2 * i), 8'(8'hA0 + i));
        end
        check("ovf_after_drop", 32'(overflow), 32'd1);
        rdy_hold = 1'b0;
        wait_drain(200);
        downloading = 1'b0;
        @(negedge clk);
        check("ovf_sticky", 32'(overflow), 32'd1);
        wait_idle(100);
        downloading = 1'b1;
        @(negedge clk);
        check("ovf_cleared_on_start", 32'(overflow), 32'd0);

        // Push into a full FIFO in the same cycle as a pop
        rdy_hold = 1'b1; prog_rdy = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            push_exp(2'd0, 23'(32'h40 + i), 8'(8'hB0 + i), 2'b10);
            drive_byte(25'(32'h80 + 2 * i), 8'(8'hB0 + i));
        end
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
        @(negedge clk);
        push_exp(2'd0, 23'h45, 8'hB5, 2'b10);
        drive_byte(25'h8A, 8'hB5);
        check("full_pushpop_no_drop", 32'(overflow), 32'd0);
        rdy_hold = 1'b0;
        wait_drain(200);
        downloading = 1'b0;
        wait_idle(100);

        // Drain after the window closes, then POST_WAIT tail
        downloading = 1'b1; rdy_hold = 1'b1; prog_rdy = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            push_exp(2'd1, 23'(32'h100 + i), 8'(8'hC0 + i), 2'b10);
            drive_byte(25'(32'h10_0200 + 2 * i), 8'(8'hC0 + i));
        end
        downloading = 1'b0;
        @(negedge clk);
        check("busy_after_dl_fall", 32'(dwnld_busy), 32'd1);
        rdy_hold = 1'b0;
        n = 0; lows = 0;
        while ((sb.size() != 0 || prog_we) && n < 200) begin
            if (!dwnld_busy) lows++;
            @(negedge clk);
            n++;
        end
        check("drain3_in_time", 32'(n < 200), 32'd1);
        check("busy_held_in_drain", 32'(lows), 32'd0);
        high = 0; falls = 0; prev = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (dwnld_busy) high++;
            if (prev && !dwnld_busy) falls++;
            prev = dwnld_busy;
            @(negedge clk);
        end
        check("busy_tail_cycles", 32'(high), 32'(POST_WAIT + 1));
        check("busy_falls_once", 32'(falls), 32'd1);

        // Reset in the middle of a write
        downloading = 1'b1; rdy_hold = 1'b1; prog_rdy = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(2'd0, 23'h300, 8'hD0, 2'b10);
        push_exp(2'd0, 23'h300, 8'hD1, 2'b01);
        drive_byte(25'h600, 8'hD0);
        drive_byte(25'h601, 8'hD1);
        downloading = 1'b0;
        @(negedge clk);
        check("we_before_rst", 32'(prog_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_we", 32'(prog_we), 32'd0);
        check("rst_mid_busy", 32'(dwnld_busy), 32'd0);
        sb.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        rdy_hold = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (prog_we) n++;
        end
        check("no_stale_write", 32'(n), 32'd0);
        check("idle_after_rst", 32'(dwnld_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
